// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array output-edge deskew logic.
//   nbeats(size)     : beats per matrix (one per anti-diagonal)
//   beat_width(size) : width of the beat counter
//   state_e          : collector FSM states
package systolic_pkg;

    function automatic int unsigned nbeats(input int unsigned size);
        return 2 * size - 1;
    endfunction

    // Guarded so a 1x1 array still gets a 1-bit counter.
    function automatic int unsigned beat_width(input int unsigned size);
        return (nbeats(size) > 1) ? $clog2(nbeats(size)) : 1;
    endfunction

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

endpackage

// File: rtl/deskew_matrix_if.sv
// Handshake bus between the skewed wavefront source, the deskew block and the
// result consumer.
//   valid_i/ready_o/skewIn : input beat handshake and data
//   valid_o/ready_i/Mout   : output matrix handshake and data
//   beat_o                 : index of the next beat to be accepted (debug)
interface deskew_matrix_if
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SIZE  = 3
);
    localparam int unsigned BW = beat_width(SIZE);

    logic                    valid_i;
    logic                    ready_o;
    logic [SIZE*WIDTH-1:0]   skewIn;
    logic                    valid_o;
    logic                    ready_i;
    logic [WIDTH-1:0]        Mout [SIZE][SIZE];
    logic [BW-1:0]           beat_o;

    modport master (
        output valid_i, skewIn, ready_i,
        input  ready_o, valid_o, Mout, beat_o
    );

    modport slave (
        input  valid_i, skewIn, ready_i,
        output ready_o, valid_o, Mout, beat_o
    );

endinterface

// File: rtl/deskew_lane.sv
// One output column of the deskew matrix. Lane LANE of beat k carries row
// k-LANE; beats outside that window leave every register untouched.
//   clock, reset : clock and async active-high reset
//   wr_en        : beat accepted this cycle
//   beat         : index of the beat being accepted
//   din          : this lane's slice of the beat
//   col          : the SIZE element registers of column LANE
module deskew_lane #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SIZE  = 3,
    parameter int unsigned LANE  = 0,
    parameter int unsigned BW    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [BW-1:0]    beat,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] col [SIZE]
);
    // One extra bit so beat - LANE cannot alias back into range.
    localparam int unsigned RW = BW + 1;

    logic [RW-1:0] beat_x;
    logic [RW-1:0] row_c;
    logic          in_win_c;

    assign beat_x   = RW'(beat);
    assign row_c    = beat_x - RW'(LANE);
    assign in_win_c = (beat_x >= RW'(LANE)) && (row_c < RW'(SIZE));

    // Element registers; at most one row is written per accepted beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < SIZE; r++) begin
                col[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < SIZE; r++) begin
                if (wr_en && in_win_c && (row_c == RW'(r))) begin
                    col[r] <= din;
                end
            end
        end
    end

endmodule

// File: rtl/deskew_matrix.sv
// Rebuilds a SIZE x SIZE matrix from the anti-diagonal wavefronts leaving the
// systolic multiplier, then holds it on a valid/ready output.
//   clock, reset : clock and async active-high reset
//   bus          : slave side of deskew_matrix_if (input beats, output matrix)
module deskew_matrix
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SIZE  = 3
) (
    input  logic             clock,
    input  logic             reset,
    deskew_matrix_if.slave   bus
);
    localparam int unsigned BW   = beat_width(SIZE);
    localparam int unsigned LAST = nbeats(SIZE) - 1;

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          accept_c;

    // State and beat counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next state; the counter parks on the last index while the matrix is held.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        accept_c = bus.valid_i && (state_q == COLLECT);
        case (state_q)
            COLLECT: begin
                if (accept_c) begin
                    if (beat_q == BW'(LAST)) begin
                        state_d = HOLD;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.ready_i) begin
                    state_d = COLLECT;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = COLLECT;
                beat_d  = '0;
            end
        endcase
    end

    // Handshake outputs decode the state register only.
    assign bus.ready_o = (state_q == COLLECT);
    assign bus.valid_o = (state_q == HOLD);
    assign bus.beat_o  = beat_q;

    // One column register bank per lane.
    for (genvar t = 0; t < SIZE; t++) begin : g_lane
        logic [WIDTH-1:0] col [SIZE];

        deskew_lane #(
            .WIDTH (WIDTH),
            .SIZE  (SIZE),
            .LANE  (t),
            .BW    (BW)
        ) u_lane (
            .clock (clock),
            .reset (reset),
            .wr_en (accept_c),
            .beat  (beat_q),
            .din   (bus.skewIn[t*WIDTH +: WIDTH]),
            .col   (col)
        );

        for (genvar r = 0; r < SIZE; r++) begin : g_row
            assign bus.Mout[r][t] = col[r];
        end
    end

endmodule
